// File: rtl/prod3_mul_sequencer.sv
// Triple-product sequencer: reads A,B,C, computes D = A*B*C by sign-magnitude shift-add, writes D.
// Optional macro PROD3_ZERO_SKIP_EN: a zero operand bypasses both multiply passes.
module prod3_mul_sequencer #(
   parameter int            AW       = 8,
   parameter logic [AW-1:0] SRC_BASE = '0,
   parameter logic [AW-1:0] DST_BASE = AW'(3)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          done,
   output logic [AW-1:0] mem_addr,
   input  logic [7:0]    mem_rd_data,
   output logic [7:0]    mem_wr_data,
   output logic          mem_we
);

   typedef enum logic [3:0] {
      IDLE, LDA, LDB, LDC, MUL1, MUL2, ST0, ST1, ST2, DONE
   } state_t;

   state_t       state, nstate;
   logic         start_q, trig;
   logic [7:0]   mag_a, mag_b, mag_c, rd_mag;
   logic         sign_a, sign_b, neg;
   logic [15:0]  acc16;
   logic [23:0]  acc24, d;
   logic [2:0]   bit_i;
   logic         skip;

   assign rd_mag = mem_rd_data[7] ? (~mem_rd_data + 8'd1) : mem_rd_data;
   assign d      = neg ? (~acc24 + 24'd1) : acc24;

`ifdef PROD3_ZERO_SKIP_EN
   assign skip = (mag_a == 8'd0) || (mag_b == 8'd0) || (rd_mag == 8'd0);
`else
   assign skip = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nstate;
   end

   // NOTE: every output is given a default before the case so no path infers a latch.
   always_comb begin
      nstate      = state;
      done        = 1'b0;
      mem_we      = 1'b0;
      mem_wr_data = 8'd0;
      unique case (state)
         IDLE: if (trig) nstate = LDA;
         LDA:  nstate = LDB;
         LDB:  nstate = LDC;
         LDC:  nstate = skip ? ST0 : MUL1;
         MUL1: if (bit_i == 3'd7) nstate = MUL2;
         MUL2: if (bit_i == 3'd7) nstate = ST0;
         ST0: begin
            mem_we      = 1'b1;
            mem_wr_data = d[7:0];
            nstate      = ST1;
         end
         ST1: begin
            mem_we      = 1'b1;
            mem_wr_data = d[15:8];
            nstate      = ST2;
         end
         ST2: begin
            mem_we      = 1'b1;
            mem_wr_data = d[23:16];
            nstate      = DONE;
         end
         DONE: begin
            // done drops on the edge that samples the trigger, one cycle before LDA
            done = ~trig;
            if (trig) nstate = LDA;
         end
         default: nstate = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         start_q  <= 1'b1;
         trig     <= 1'b0;
         mag_a    <= 8'd0;
         mag_b    <= 8'd0;
         mag_c    <= 8'd0;
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
         neg      <= 1'b0;
         acc16    <= 16'd0;
         acc24    <= 24'd0;
         bit_i    <= 3'd0;
         mem_addr <= '0;
      end else begin
         start_q <= start;
         trig    <= (state == IDLE || state == DONE) && start_q && !start && !trig;

         case (state)
            LDA: begin
               mag_a  <= rd_mag;
               sign_a <= mem_rd_data[7];
               acc16  <= 16'd0;
               acc24  <= 24'd0;
               bit_i  <= 3'd0;
            end
            LDB: begin
               mag_b  <= rd_mag;
               sign_b <= mem_rd_data[7];
            end
            LDC: begin
               mag_c <= rd_mag;
               neg   <= sign_a ^ sign_b ^ mem_rd_data[7];
            end
            MUL1: begin
               if (mag_b[bit_i]) acc16 <= acc16 + (16'(mag_a) << bit_i);
               bit_i <= bit_i + 3'd1;
            end
            MUL2: begin
               if (mag_c[bit_i]) acc24 <= acc24 + (24'(acc16) << bit_i);
               bit_i <= bit_i + 3'd1;
            end
            default: ;
         endcase

         // address is registered from the next state so it is stable for the whole cycle
         case (nstate)
            LDA:     mem_addr <= SRC_BASE;
            LDB:     mem_addr <= SRC_BASE + AW'(1);
            LDC:     mem_addr <= SRC_BASE + AW'(2);
            ST0:     mem_addr <= DST_BASE;
            ST1:     mem_addr <= DST_BASE + AW'(1);
            ST2:     mem_addr <= DST_BASE + AW'(2);
            default: mem_addr <= mem_addr;
         endcase
      end
   end

endmodule

// File: doc/prod3_mul_sequencer.md
Name: prod3_mul_sequencer

Overview:
Hardware sequencer that computes the program-3 triple product D = A * B * C without the core executing the shift-add loop.
- Operands A, B, C are 8-bit two's-complement; D is a 24-bit two's-complement result.
- The block masters the data-memory port. It reads A, B and C from SRC_BASE..SRC_BASE+2.
- It runs a sign-magnitude shift-add multiply over two 8-iteration passes.
- It writes D little-endian to DST_BASE..DST_BASE+2 and then raises done.
- It uses the same start/done handshake as top_level.

Parameters:
AW, 8, data-memory address width
SRC_BASE, 0, address of A (B at +1, C at +2)
DST_BASE, 3, address of D low byte (mid at +1, high at +2)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
start  input  1  a falling edge (1->0) requests a run
done  output  1  high when the result is stored; sticky
mem_addr  output  AW  data-memory address
mem_rd_data  input  8  data-memory read data; combinational, valid in the same cycle as mem_addr
mem_wr_data  output  8  data-memory write data
mem_we  output  1  write enable; memory writes on the rising clk edge

Behaviour:
Reset (asynchronous):
- state=IDLE, done=0, mem_we=0, mem_addr=0, mem_wr_data=0.
- Internal accumulators and start_q are cleared (start_q=1 so no false edge after reset).
- Reset asserted mid-run aborts immediately. Writes already made stay in memory; no further writes occur.

Start detect:
- start is registered into start_q every cycle.
- The trigger is start_q=1 && start=0, sampled in IDLE or DONE only. Start activity in any other state is ignored.

FSM (one cycle per state unless noted):
- IDLE: done=0. On trigger -> LDA.
- LDA: mem_addr=SRC_BASE. Latch |A| (8-bit unsigned; -128 -> 0x80) and sign sA. -> LDB.
- LDB: same for B at SRC_BASE+1. -> LDC.
- LDC: same for C at SRC_BASE+2. neg = sA^sB^sC. -> MUL1.
- MUL1: 8 cycles, bit counter i=0..7. If |B|[i]=1, acc16 += |A|<<i. Counter wraps to 0 -> MUL2.
- MUL2: 8 cycles. If |C|[i]=1, acc24 += acc16<<i. Then -> ST0.
- Before ST0, D = neg ? -acc24 : acc24, taken modulo 2^24.
- ST0 / ST1 / ST2: mem_we=1, mem_addr=DST_BASE+0/1/2, mem_wr_data=D[7:0] / D[15:8] / D[23:16].
- DONE: done=1, mem_we=0. Stays here until trigger (-> LDA, done drops on that edge) or reset.

Arithmetic:
- Maximum magnitude is 128^3 = 2^21, so no overflow is possible in 24 bits.
- The negate is applied once, after the magnitude product, so a zero result is never emitted as a negative value.

Latency:
- Sampling edge (trigger seen) = E.
- LDA is entered on E+1; done rises on E+23.
- The three writes occur on edges E+21..E+23.

Bus rules:
- mem_we is high only in ST0..ST2.
- mem_addr is stable for the whole cycle.
- Read addresses are driven only in LDA..LDC; mem_addr holds its last value elsewhere.

Optional Feature:
Macro: PROD3_ZERO_SKIP_EN
- Defined: in LDC, if |A|, |B| or |C| is 0, force D=0 and go LDC -> ST0, skipping MUL1/MUL2. done then rises on E+7.
- Undefined: always run both 8-cycle passes. Latency is fixed at E+23 for all operands.

Test Plan:
- A=-63, B=-44, C=-62 -> mem[5..3]=FD 60 A8 (-171864); done rises exactly 23 edges after the sampling edge; mem[0..2] unchanged.
- A=-128, B=-128, C=-128 -> mem[5..3]=E0 00 00 (-2097152). A=127, B=127, C=127 -> 1F 41 7F (2048383).
- A=5, B=0, C=-7 -> mem[5..3]=00 00 00. done at E+23 without the macro, E+7 with PROD3_ZERO_SKIP_EN.
- Handshake: reset held with start=1, then release -> done stays 0 for 200 ns. Toggling start 1->0->1 during MUL1 -> no restart. Falling start while in DONE -> done drops next edge and a second run with new operands writes the correct product.
- Reset mid-run: assert reset asynchronously during MUL2 -> done=0, mem_we=0 immediately, state IDLE, mem[3..5] not written. Then a new start fall -> correct result.
- Bus check: mem_we is high for exactly 3 consecutive cycles per run, with mem_addr 3, 4, 5 in order; no write occurs to any other address.
